// File: rtl/nic_vc_allocator_pkg.sv
// Shared NIC parameters and helpers for the VC allocator slice.
// Sizes here must match the NIC-wide defines used by fifo_nic2noc.
package nic_vc_allocator_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    localparam int N_OF_VN           = 2;
    localparam int N_OF_VC           = 3;
    localparam int N_TOT_OF_VC       = N_OF_VC * N_OF_VN;
    localparam int N_FIFO_OUT_BUFFER = 8;
    localparam int FLIT_WIDTH        = 32;

    localparam int N_BITS_POINTER  = clog2(N_FIFO_OUT_BUFFER);
    // A single VN still needs a 1-bit id field on the request bus.
    localparam int N_BITS_VN       = (clog2(N_OF_VN) < 1) ? 1 : clog2(N_OF_VN);
    localparam int N_BITS_VC_IDX   = (clog2(N_TOT_OF_VC) < 1) ? 1 : clog2(N_TOT_OF_VC);
    localparam int N_BITS_LOCAL_VC = (clog2(N_OF_VC) < 1) ? 1 : clog2(N_OF_VC);

    typedef logic [N_BITS_POINTER-1:0]  buf_id_t;
    typedef logic [N_BITS_VN-1:0]       vn_id_t;
    typedef logic [N_BITS_LOCAL_VC-1:0] vc_local_t;
    typedef logic [N_BITS_VC_IDX-1:0]   vc_idx_t;

endpackage

// File: rtl/nic_vc_allocator_if.sv
// Request/grant bundle between the output-buffer requesters, the VC allocator
// and fifo_nic2noc. The master modport is the allocator side.
interface nic_vc_allocator_if;
    import nic_vc_allocator_pkg::*;

    logic [N_FIFO_OUT_BUFFER-1:0]             buffer_req_i;
    logic [N_FIFO_OUT_BUFFER*N_BITS_VN-1:0]   buffer_vn_i;
    logic [N_FIFO_OUT_BUFFER-1:0]             buffer_grant_o;
    logic [N_TOT_OF_VC-1:0]                   fifo_pointer_state_i;
    logic [N_TOT_OF_VC-1:0]                   g_fifo_pointer_o;
    logic [N_TOT_OF_VC*N_BITS_POINTER-1:0]    g_fifo_out_buffer_id_o;
    logic [N_BITS_VC_IDX-1:0]                 granted_vc_o;

    modport master (
        input  buffer_req_i,
        input  buffer_vn_i,
        input  fifo_pointer_state_i,
        output buffer_grant_o,
        output g_fifo_pointer_o,
        output g_fifo_out_buffer_id_o,
        output granted_vc_o
    );

    modport slave (
        output buffer_req_i,
        output buffer_vn_i,
        output fifo_pointer_state_i,
        input  buffer_grant_o,
        input  g_fifo_pointer_o,
        input  g_fifo_out_buffer_id_o,
        input  granted_vc_o
    );

endinterface

// File: rtl/nic_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
// Produces a one-hot grant plus the winner's index (both zero if no request).
module nic_rr_arbiter
    import nic_vc_allocator_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int p;
            p = (int'(ptr) + k) % N;
            if (!found && req[IW'(p)]) begin
                found           = 1'b1;
                grant[IW'(p)]   = 1'b1;
                idx             = IW'(p);
            end
        end
    end

endmodule

// File: rtl/nic_vc_allocator.sv
// NIC injection VC allocator: one round-robin buffer grant per cycle bound to a
// free VC of its VN. Optional stats ports are enabled by NIC_VCA_STATS_EN.
module nic_vc_allocator
    import nic_vc_allocator_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    nic_vc_allocator_if.master     bus
`ifdef NIC_VCA_STATS_EN
    ,
    output logic [15:0]            grant_count_o,
    output logic [N_OF_VN-1:0]     blocked_o
`endif
);

    localparam int NB  = N_FIFO_OUT_BUFFER;
    localparam int NT  = N_TOT_OF_VC;
    localparam int NBP = N_BITS_POINTER;
    localparam int NBV = N_BITS_VN;

    logic [NB-1:0]      buffer_grant_reg, buffer_grant_next;
    logic [NT-1:0]      g_fifo_pointer_reg, g_fifo_pointer_next;
    logic [NT*NBP-1:0]  buffer_id_reg, buffer_id_next;
    vc_idx_t            granted_vc_reg, granted_vc_next;
    buf_id_t            buf_rr_ptr_reg, buf_rr_ptr_next;
    vc_local_t          vc_rr_ptr_reg  [N_OF_VN];
    vc_local_t          vc_rr_ptr_next [N_OF_VN];

    logic [NT-1:0]         vc_free;
    logic [NB-1:0]         req_eff;
    logic [N_OF_VN-1:0]    vn_free;
    logic [NB*N_OF_VN-1:0] vn_match;
    logic [NB-1:0]         eligible;
    logic [NB-1:0]         buf_grant;
    buf_id_t               buf_idx;
    logic [N_OF_VN-1:0]    sel_vn;
    logic [N_OF_VC-1:0]    vc_grant [N_OF_VN];
    vc_local_t             vc_idx   [N_OF_VN];

    // The registered grant covers fifo_nic2noc's one-cycle state lag and the
    // requester's one-cycle request drop lag.
    assign vc_free = ~(bus.fifo_pointer_state_i | g_fifo_pointer_reg);
    assign req_eff = bus.buffer_req_i & ~buffer_grant_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_OF_VN; gi++) begin : g_vn
            assign vn_free[gi] = |vc_free[gi*N_OF_VC +: N_OF_VC];

            nic_rr_arbiter #(
                .N  (N_OF_VC),
                .IW (N_BITS_LOCAL_VC)
            ) u_vc_arb (
                .req   (vc_free[gi*N_OF_VC +: N_OF_VC]),
                .ptr   (vc_rr_ptr_reg[gi]),
                .grant (vc_grant[gi]),
                .idx   (vc_idx[gi])
            );
        end

        // An out-of-range VN id matches no VN and is therefore never eligible.
        for (gi = 0; gi < NB; gi++) begin : g_buf
            for (gj = 0; gj < N_OF_VN; gj++) begin : g_match
                assign vn_match[gi*N_OF_VN + gj] =
                    (bus.buffer_vn_i[gi*NBV +: NBV] == NBV'(gj));
            end
            assign eligible[gi] = req_eff[gi] & |(vn_match[gi*N_OF_VN +: N_OF_VN] & vn_free);
        end
    endgenerate

    nic_rr_arbiter #(
        .N  (NB),
        .IW (NBP)
    ) u_buf_arb (
        .req   (eligible),
        .ptr   (buf_rr_ptr_reg),
        .grant (buf_grant),
        .idx   (buf_idx)
    );

    always_comb begin
        sel_vn = '0;
        for (int b = 0; b < NB; b++) begin
            if (buf_grant[b]) begin
                sel_vn = sel_vn | vn_match[b*N_OF_VN +: N_OF_VN];
            end
        end
    end

    always_comb begin
        buffer_grant_next   = buf_grant;
        g_fifo_pointer_next = '0;
        buffer_id_next      = '0;
        granted_vc_next     = '0;
        buf_rr_ptr_next     = buf_rr_ptr_reg;
        for (int v = 0; v < N_OF_VN; v++) begin
            vc_rr_ptr_next[v] = vc_rr_ptr_reg[v];
        end
        if (|buf_grant) begin
            buf_rr_ptr_next = (buf_idx == NBP'(NB - 1)) ? '0 : buf_idx + 1'b1;
            for (int v = 0; v < N_OF_VN; v++) begin
                if (sel_vn[v]) begin
                    g_fifo_pointer_next[v*N_OF_VC +: N_OF_VC] = vc_grant[v];
                    granted_vc_next   = N_BITS_VC_IDX'(v * N_OF_VC) + N_BITS_VC_IDX'(vc_idx[v]);
                    vc_rr_ptr_next[v] = (vc_idx[v] == N_BITS_LOCAL_VC'(N_OF_VC - 1)) ?
                                        '0 : vc_idx[v] + 1'b1;
                end
            end
            for (int k = 0; k < NT; k++) begin
                if (g_fifo_pointer_next[k]) begin
                    buffer_id_next[k*NBP +: NBP] = buf_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buffer_grant_reg   <= '0;
            g_fifo_pointer_reg <= '0;
            buffer_id_reg      <= '0;
            granted_vc_reg     <= '0;
            buf_rr_ptr_reg     <= '0;
            for (int v = 0; v < N_OF_VN; v++) begin
                vc_rr_ptr_reg[v] <= '0;
            end
        end else begin
            buffer_grant_reg   <= buffer_grant_next;
            g_fifo_pointer_reg <= g_fifo_pointer_next;
            buffer_id_reg      <= buffer_id_next;
            granted_vc_reg     <= granted_vc_next;
            buf_rr_ptr_reg     <= buf_rr_ptr_next;
            for (int v = 0; v < N_OF_VN; v++) begin
                vc_rr_ptr_reg[v] <= vc_rr_ptr_next[v];
            end
        end
    end

    assign bus.buffer_grant_o         = buffer_grant_reg;
    assign bus.g_fifo_pointer_o       = g_fifo_pointer_reg;
    assign bus.g_fifo_out_buffer_id_o = buffer_id_reg;
    assign bus.granted_vc_o           = granted_vc_reg;

`ifdef NIC_VCA_STATS_EN
    logic [15:0]        grant_count_reg;
    logic [N_OF_VN-1:0] blocked_reg, blocked_next;
    logic [N_OF_VN-1:0] vn_req;

    // Raw requests count here: a VN with any waiter and no free VC is blocked.
    always_comb begin
        vn_req = '0;
        for (int b = 0; b < NB; b++) begin
            if (bus.buffer_req_i[b]) begin
                vn_req = vn_req | vn_match[b*N_OF_VN +: N_OF_VN];
            end
        end
        blocked_next = vn_req & ~vn_free;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_count_reg <= '0;
            blocked_reg     <= '0;
        end else begin
            blocked_reg <= blocked_next;
            if (|buf_grant && grant_count_reg != 16'hFFFF) begin
                grant_count_reg <= grant_count_reg + 16'd1;
            end
        end
    end

    assign grant_count_o = grant_count_reg;
    assign blocked_o     = blocked_reg;
`endif

endmodule

// File: tb/tb_nic_vc_allocator.sv
// Self-checking bench for nic_vc_allocator: directed scenarios plus random
// traffic against a queue-free arithmetic reference of the allocation rules.
module tb_nic_vc_allocator;
    import nic_vc_allocator_pkg::*;

    localparam int NB  = N_FIFO_OUT_BUFFER;
    localparam int NT  = N_TOT_OF_VC;
    localparam int NBP = N_BITS_POINTER;
    localparam int NBV = N_BITS_VN;
    localparam int NVI = N_BITS_VC_IDX;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nic_vc_allocator_if bus();

`ifdef NIC_VCA_STATS_EN
    logic [15:0]        grant_count;
    logic [N_OF_VN-1:0] blocked;
`endif

    nic_vc_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef NIC_VCA_STATS_EN
        ,
        .grant_count_o (grant_count),
        .blocked_o     (blocked)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [NB-1:0] req_v;
    int            vn_v [NB];
    logic [NT-1:0] state_v;

    int m_buf_ptr;
    int m_vc_ptr [N_OF_VN];
    int m_prev_buf;
    int m_prev_vc;
    int m_count;

    logic [NB-1:0]     exp_bg;
    logic [NT-1:0]     exp_gp;
    logic [NT*NBP-1:0] exp_id;
    logic [NVI-1:0]    exp_vc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        bus.buffer_req_i = req_v;
        for (int b = 0; b < NB; b++) begin
            bus.buffer_vn_i[b*NBV +: NBV] = NBV'(vn_v[b]);
        end
        bus.fifo_pointer_state_i = state_v;
    endtask

    task automatic model_reset();
        m_buf_ptr  = 0;
        m_prev_buf = -1;
        m_prev_vc  = -1;
        m_count    = 0;
        for (int v = 0; v < N_OF_VN; v++) m_vc_ptr[v] = 0;
    endtask

    function automatic bit vn_has_free(input logic [NT-1:0] busy, input int vn);
        for (int l = 0; l < N_OF_VC; l++) begin
            if (!busy[vn*N_OF_VC + l]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Rules: skip the buffer already granted, skip VNs with every VC busy
    // (state or the VC bound last cycle), round-robin on buffers then VCs.
    task automatic predict();
        logic [NT-1:0] busy;
        int sel, vc, vn, lv;
        busy = state_v;
        if (m_prev_vc >= 0) busy[m_prev_vc] = 1'b1;
        sel = -1; vc = -1; vn = 0; lv = 0;
        for (int k = 0; k < NB; k++) begin
            int b;
            b = (m_buf_ptr + k) % NB;
            if (sel < 0 && req_v[b] && b != m_prev_buf && vn_v[b] < N_OF_VN &&
                vn_has_free(busy, vn_v[b])) sel = b;
        end
        exp_bg = '0; exp_gp = '0; exp_id = '0; exp_vc = '0;
        if (sel >= 0) begin
            vn = vn_v[sel];
            for (int k = 0; k < N_OF_VC; k++) begin
                int l;
                l = (m_vc_ptr[vn] + k) % N_OF_VC;
                if (vc < 0 && !busy[vn*N_OF_VC + l]) begin
                    vc = vn*N_OF_VC + l;
                    lv = l;
                end
            end
            exp_bg[sel] = 1'b1;
            exp_gp[vc]  = 1'b1;
            exp_id[vc*NBP +: NBP] = NBP'(sel);
            exp_vc = NVI'(vc);
            m_buf_ptr    = (sel + 1) % NB;
            m_vc_ptr[vn] = (lv + 1) % N_OF_VC;
            if (m_count < 65535) m_count++;
        end
        m_prev_buf = sel;
        m_prev_vc  = vc;
    endtask

    task automatic step();
        drive();
        predict();
        @(posedge clk);
        #1;
        cyc++;
        check_eq("buffer_grant", 64'(bus.buffer_grant_o), 64'(exp_bg));
        check_eq("g_fifo_pointer", 64'(bus.g_fifo_pointer_o), 64'(exp_gp));
        check_eq("buffer_id", 64'(bus.g_fifo_out_buffer_id_o), 64'(exp_id));
        check_eq("granted_vc", 64'(bus.granted_vc_o), 64'(exp_vc));
`ifdef NIC_VCA_STATS_EN
        check_eq("grant_count", 64'(grant_count), 64'(m_count));
`endif
        $display("cyc=%0d req=%b state=%b grant=%b vc_bind=%b vc=%0d",
                 cyc, req_v, state_v, bus.buffer_grant_o, bus.g_fifo_pointer_o, bus.granted_vc_o);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_bg"}, 64'(bus.buffer_grant_o), 64'd0);
        check_eq({tag, "_gp"}, 64'(bus.g_fifo_pointer_o), 64'd0);
        check_eq({tag, "_id"}, 64'(bus.g_fifo_out_buffer_id_o), 64'd0);
        check_eq({tag, "_vc"}, 64'(bus.granted_vc_o), 64'd0);
    endtask

    task automatic clear_inputs();
        req_v   = '0;
        state_v = '0;
        for (int b = 0; b < NB; b++) vn_v[b] = 0;
    endtask

    // Reset with random inputs applied; release away from the clock edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        req_v   = NB'($urandom);
        state_v = NT'($urandom);
        for (int b = 0; b < NB; b++) vn_v[b] = int'($urandom_range(0, N_OF_VN - 1));
        drive();
        #1 check_zero("rst_async");
        @(posedge clk);
        #1 check_zero("rst_hold");
        clear_inputs();
        drive();
        model_reset();
        rst = 1'b1;
    endtask

    initial begin : main
        logic [NB-1:0] drop;
        logic [NT-1:0] gp_last;
        logic [NT-1:0] rel;
        int exp_buf_seq [4];
        int exp_vc_seq  [4];

        exp_buf_seq = '{0, 5, 0, 5};
        exp_vc_seq  = '{3, 4, 5, 3};
        clear_inputs();
        model_reset();
        drive();

        // Power-on reset with random inputs, then idle.
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 3; i++) step();

        // Single request.
        do_reset();
        req_v[3] = 1'b1; vn_v[3] = 0;
        step();
        check_eq("single_gp", 64'(bus.g_fifo_pointer_o), 64'b000001);
        check_eq("single_bg", 64'(bus.buffer_grant_o), 64'b00001000);
        check_eq("single_id", 64'(bus.g_fifo_out_buffer_id_o), 64'd3);
        step();
        check_eq("single_pulse", 64'(bus.g_fifo_pointer_o), 64'd0);
        req_v = '0;
        step();

        // Back-to-back masking.
        do_reset();
        req_v[1] = 1'b1; vn_v[1] = 1;
        req_v[2] = 1'b1; vn_v[2] = 1;
        step();
        check_eq("b2b_bg1", 64'(bus.buffer_grant_o), 64'b00000010);
        check_eq("b2b_gp1", 64'(bus.g_fifo_pointer_o), 64'b001000);
        step();
        check_eq("b2b_bg2", 64'(bus.buffer_grant_o), 64'b00000100);
        check_eq("b2b_gp2", 64'(bus.g_fifo_pointer_o), 64'b010000);
        req_v[1] = 1'b0;
        step();
        check_eq("b2b_norepeat", 64'(bus.buffer_grant_o), 64'd0);
        req_v = '0;
        step();

        // VN0 full: VN1 proceeds, VN0 waits until a VC frees.
        do_reset();
        state_v  = 6'b000111;
        req_v[0] = 1'b1; vn_v[0] = 0;
        req_v[4] = 1'b1; vn_v[4] = 1;
        step();
        check_eq("full_bg", 64'(bus.buffer_grant_o), 64'b00010000);
        check_eq("full_gp", 64'(bus.g_fifo_pointer_o), 64'b001000);
        state_v = 6'b001101;
        step();
        check_eq("free_bg", 64'(bus.buffer_grant_o), 64'b00000001);
        check_eq("free_gp", 64'(bus.g_fifo_pointer_o), 64'b000010);
        clear_inputs();
        step();

        // Fairness between two persistent requesters on VN1.
        do_reset();
        req_v[0] = 1'b1; vn_v[0] = 1;
        req_v[5] = 1'b1; vn_v[5] = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("fair_buf", 64'(bus.buffer_grant_o), 64'(1) << exp_buf_seq[i]);
            check_eq("fair_vc", 64'(bus.granted_vc_o), 64'(exp_vc_seq[i]));
        end

        // Asynchronous reset while a grant pulse is on the outputs.
        check_eq("pre_rst_pulse", 64'(|bus.g_fifo_pointer_o), 64'd1);
        do_reset();
        req_v[0] = 1'b1; vn_v[0] = 0;
        req_v[5] = 1'b1; vn_v[5] = 0;
        step();
        check_eq("post_rst_bg", 64'(bus.buffer_grant_o), 64'b00000001);
        check_eq("post_rst_gp", 64'(bus.g_fifo_pointer_o), 64'b000001);
        clear_inputs();
        step();

        // Random traffic with a fifo_nic2noc-like state environment.
        do_reset();
        drop    = '0;
        gp_last = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < NB; b++) begin
                if (drop[b]) begin
                    req_v[b] = 1'b0;
                end else if (!req_v[b] && $urandom_range(0, 2) == 0) begin
                    req_v[b] = 1'b1;
                    vn_v[b]  = int'($urandom_range(0, N_OF_VN - 1));
                end
            end
            drop    = bus.buffer_grant_o;
            rel     = NT'($urandom & $urandom);
            state_v = (state_v & ~rel) | gp_last;
            gp_last = bus.g_fifo_pointer_o;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/nic_vc_allocator.md
Name: nic_vc_allocator

Overview:
- Virtual-channel allocator on the NIC injection side, between the output-buffer requesters and fifo_nic2noc.
- Each cycle it picks at most one requesting output buffer (round-robin) and binds it to a free VC of that buffer's virtual network (round-robin per VN).
- It drives fifo_nic2noc's grant inputs (g_fifo_pointer, g_fifo_out_buffer_id) and reads back fifo_pointer_state to know which VCs are taken.

Parameters:
N_OF_VN, 2, number of virtual networks
N_OF_VC, 3, VCs per VN
N_TOT_OF_VC, N_OF_VC*N_OF_VN, total VCs; VC index = vn*N_OF_VC + vc
N_FIFO_OUT_BUFFER, 8, number of output buffers (requesters)
N_BITS_POINTER, clog2(N_FIFO_OUT_BUFFER), buffer-id width
N_BITS_VN, clog2(N_OF_VN), VN-id width (minimum 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
buffer_req_i  in  N_FIFO_OUT_BUFFER  level request per output buffer; held until granted
buffer_vn_i  in  N_FIFO_OUT_BUFFER*N_BITS_VN  requested VN per buffer; slice b belongs to buffer b
buffer_grant_o  out  N_FIFO_OUT_BUFFER  one-hot, one-cycle grant pulse
fifo_pointer_state_i  in  N_TOT_OF_VC  1 = VC busy (from fifo_nic2noc)
g_fifo_pointer_o  out  N_TOT_OF_VC  one-hot, one-cycle VC bind pulse (to fifo_nic2noc)
g_fifo_out_buffer_id_o  out  N_TOT_OF_VC*N_BITS_POINTER  granted buffer id, written into the slice of the granted VC
granted_vc_o  out  clog2(N_TOT_OF_VC)  index of granted VC, valid with the grant pulse

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, all round-robin pointers 0.
- Registered outputs; latency 1: a request visible in cycle N is granted in cycle N+1 at the earliest.
- At most one grant per cycle. buffer_grant_o and g_fifo_pointer_o are asserted in the same cycle, for exactly one cycle.
- Effective busy mask = fifo_pointer_state_i | g_fifo_pointer_o (current registered grant). This covers the one-cycle delay before fifo_nic2noc updates its state, so no VC is ever double-bound.
- Effective request mask = buffer_req_i & ~buffer_grant_o. This ignores a requester in its grant cycle, so no buffer is ever double-granted.
- Eligible buffer b: its effective request is set and its VN has at least one VC free in the effective busy mask.
- Buffer arbitration: round-robin among eligible buffers, starting at buf_rr_ptr. After a grant to buffer b, buf_rr_ptr = (b+1) mod N_FIFO_OUT_BUFFER. With no grant the pointer holds.
- VC selection: round-robin among free VCs of the chosen VN, starting at vc_rr_ptr[vn]. After a grant to local vc v, vc_rr_ptr[vn] = (v+1) mod N_OF_VC. Other VNs' pointers hold.
- g_fifo_out_buffer_id_o: only the granted VC's slice carries the buffer id; every other slice is 0. All slices are 0 when there is no grant.
- buffer_vn_i >= N_OF_VN: the request is ineligible and never granted.
- All VCs of a VN busy: requests for that VN wait; requests for other VNs still proceed.
- Reset asserted mid-grant: the pulse is cut immediately and pointers return to 0.

Optional Feature:
- Macro: NIC_VCA_STATS_EN.
- Defined: adds output grant_count_o [15:0]. It increments on every grant, saturates at 16'hFFFF and is cleared by reset.
- Also adds blocked_o [N_OF_VN-1:0]. It is registered, and bit v is high while any request for VN v exists and no VC of VN v is free.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package/defines: N_OF_VN, N_OF_VC, N_FIFO_OUT_BUFFER, FLIT_WIDTH (existing NIC-defines), and clog2 (existing NIC_utils).
- Sub-module nic_rr_arbiter, parameterised on N. Inputs: request vector and pointer. Outputs: one-hot grant and index.
- Instance count: one instance for buffer arbitration, plus N_OF_VN instances (generate loop) for VC selection.

Test Plan:
- Reset: rst=0 with random inputs -> all outputs 0. Release rst; idle inputs -> outputs stay 0.
- Single request: buffer 3 requests VN0, state=0 -> next cycle g_fifo_pointer_o=6'b000001, buffer_grant_o=8'b00001000, id slice0=3'd3, one-cycle pulse.
- Back-to-back masking: buffers 1 and 2 request VN1, held, state held at 0 -> cycle 1: buffer 1 to 6'b001000; cycle 2: buffer 2 to 6'b010000; no repeat VC and no repeat buffer.
- VN full: state=6'b000111, buffer 0 requests VN0 and buffer 4 requests VN1 -> buffer 4 gets 6'b001000, buffer 0 waits. Clear state bit 1 -> buffer 0 gets 6'b000010 the next cycle.
- Fairness: buffers 0 and 5 continuously request VN1, state toggled free each cycle -> grants alternate 0,5,0,5 and VCs rotate 3,4,5,3.
- Async reset during a grant pulse: drop rst mid-cycle -> outputs clear without waiting for a clock edge. After release, the first grant starts from buffer 0 / VC0 priority.
